axi_master: RTL and testbench

AXI_MASTER -- requirements
Module: axi_master

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the single-beat master and the slave-side blocks:
// burst/size/response encodings and the transaction FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } axi_state_e;

endpackage

// File: rtl/axi_master.sv
// Single-outstanding, single-beat AXI master: one command in, one AXI
// transaction out, one registered completion pulse back.
module axi_master
    import axi_pkg::*;
#(
    parameter int addr_width   = 3,
    parameter int data_width   = 32,
    parameter int strb         = 4,
    parameter int resp         = 2,
    parameter int len          = 8,
    parameter int size         = 3,
    parameter int burst_length = 2,
    parameter int cache        = 4,
    parameter int prot         = 3
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [strb-1:0]         cmd_wstrb,

    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [data_width-1:0]   rsp_rdata,
    output logic [resp-1:0]         rsp_resp,

    output logic                    awid,
    output logic [addr_width-1:0]   awaddr,
    output logic [len-1:0]          awlen,
    output logic [size-1:0]         awsize,
    output logic [burst_length-1:0] awburst,
    output logic                    awlock,
    output logic [cache-1:0]        awcache,
    output logic [prot-1:0]         awprot,
    output logic                    awqos,
    output logic                    awregion,
    output logic                    awuser,
    output logic                    awvalid,
    input  logic                    awready,

    output logic                    wid,
    output logic [data_width-1:0]   wdata,
    output logic [strb-1:0]         wstrb,
    output logic                    wlast,
    output logic                    wuser,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic                    bid,
    input  logic [resp-1:0]         bresp,
    input  logic                    buser,
    input  logic                    bvalid,
    output logic                    bready,

    output logic                    arid,
    output logic [addr_width-1:0]   araddr,
    output logic [len-1:0]          arlen,
    output logic [size-1:0]         arsize,
    output logic [burst_length-1:0] arburst,
    output logic                    arlock,
    output logic [cache-1:0]        arcache,
    output logic [prot-1:0]         arprot,
    output logic                    arqos,
    output logic                    arregion,
    output logic                    aruser,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic                    rid,
    input  logic [data_width-1:0]   rdata,
    input  logic [resp-1:0]         rresp,
    input  logic                    rlast,
    input  logic                    ruser,
    input  logic                    rvalid,
    output logic                    rready
);

    axi_state_e              state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [addr_width-1:0]   awaddr_q, awaddr_d;
    logic [addr_width-1:0]   araddr_q, araddr_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic [strb-1:0]         wstrb_q, wstrb_d;
    logic [data_width-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [resp-1:0]         rsp_resp_q, rsp_resp_d;

    logic unused_ids;
    assign unused_ids = ^{bid, buser, rid, ruser};

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_write) begin
                        state_d   = WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once neither is pending
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_q) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                end else begin
                    bready_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    // a single-beat read must end with rlast; anything else is a slave error
                    rsp_resp_d  = rlast ? rresp : RESP_SLVERR;
                end else begin
                    rready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign awid     = 1'b0;
    assign awaddr   = awaddr_q;
    assign awlen    = '0;
    assign awsize   = SIZE_4B;
    assign awburst  = BURST_INCR;
    assign awlock   = 1'b0;
    assign awcache  = '0;
    assign awprot   = '0;
    assign awqos    = 1'b0;
    assign awregion = 1'b0;
    assign awuser   = 1'b0;
    assign awvalid  = awvalid_q;

    assign wid    = 1'b0;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = wvalid_q;
    assign wuser  = 1'b0;
    assign wvalid = wvalid_q;

    assign bready = bready_q;

    assign arid     = 1'b0;
    assign araddr   = araddr_q;
    assign arlen    = '0;
    assign arsize   = SIZE_4B;
    assign arburst  = BURST_INCR;
    assign arlock   = 1'b0;
    assign arcache  = '0;
    assign arprot   = '0;
    assign arqos    = 1'b0;
    assign arregion = 1'b0;
    assign aruser   = 1'b0;
    assign arvalid  = arvalid_q;

    assign rready = rready_q;

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: a delay-programmable slave plus a
// transaction-level model checked against the DUT on every falling edge.
module tb_axi_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awid, awlock, awqos, awregion, awuser, awvalid, awready;
    logic [2:0]  awaddr, awsize, awprot;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        wid, wlast, wuser, wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bid, buser, bvalid, bready;
    logic [1:0]  bresp;
    logic        arid, arlock, arqos, arregion, aruser, arvalid, arready;
    logic [2:0]  araddr, arsize, arprot;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        rid, rlast, ruser, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    always #5 aclk = ~aclk;

    axi_master #(
        .addr_width(3), .data_width(32), .strb(4), .resp(2), .len(8),
        .size(3), .burst_length(2), .cache(4), .prot(3)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    int unsigned nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // slave configuration, set by the stimulus before each command
    int unsigned cfg_aw, cfg_w, cfg_ar, cfg_b, cfg_r;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    logic        cfg_rlast;

    // slave state
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          b_pend, r_pend;

    // transaction model
    bit          active, t_write, b_issued, b_done, r_done;
    logic [2:0]  t_addr;
    logic [31:0] t_data, exp_rdata;
    logic [3:0]  t_strb;
    logic [1:0]  exp_resp;
    int unsigned aw_n, w_n, ar_n;
    int unsigned cyc = 0, acc_cyc, acc_cnt = 0, rsp_cnt = 0;
    int unsigned last_lat;
    logic [1:0]  last_resp;
    logic [31:0] last_rdata;
    logic        last_write;
    logic [6:0]  exp_ctl;
    logic [24:0] fixed_exp;

    initial fixed_exp = {1'b0, 8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0};

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            active = 0; b_pend = 0; r_pend = 0; b_issued = 0; b_done = 0; r_done = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            bresp = '0; rresp = '0; rdata = '0; rlast = 0;
            chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, '0);
        end else begin
            awready = awvalid && (aw_cnt >= cfg_aw); aw_cnt = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid  && (w_cnt  >= cfg_w);  w_cnt  = wvalid  ? w_cnt + 1  : 0;
            arready = arvalid && (ar_cnt >= cfg_ar); ar_cnt = arvalid ? ar_cnt + 1 : 0;
            bvalid  = b_pend && (b_cnt >= cfg_b);    if (b_pend) b_cnt++;
            bresp   = bvalid ? cfg_bresp : 2'b11;
            rvalid  = r_pend && (r_cnt >= cfg_r);    if (r_pend) r_cnt++;
            rdata   = rvalid ? cfg_rdata : 32'hA5A5_5A5A;
            rresp   = rvalid ? cfg_rresp : 2'b11;
            rlast   = rvalid ? cfg_rlast : 1'b0;

            exp_ctl = {!active,
                       active &&  t_write && aw_n == 0,
                       active &&  t_write && w_n == 0,
                       active && !t_write && ar_n == 0,
                       active &&  t_write && aw_n > 0 && w_n > 0 && !b_done,
                       active && !t_write && ar_n > 0 && !r_done,
                       active && (b_done || r_done)};
            chk("ctl{cmd_ready,awv,wv,arv,bready,rready,rsp_valid}",
                {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, exp_ctl);
            chk("aw_fixed", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser}, fixed_exp);
            chk("ar_fixed", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser}, fixed_exp);
            chk("w_fixed", {wid, wuser}, 2'b00);
            if (awvalid) chk("awaddr", awaddr, t_addr);
            if (arvalid) chk("araddr", araddr, t_addr);
            if (wvalid) begin
                chk("wdata", wdata, t_data);
                chk("wstrb", wstrb, t_strb);
                chk("wlast", wlast, 1'b1);
            end
            if (rsp_valid) begin
                chk("rsp_write", rsp_write, t_write);
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp", rsp_resp, exp_resp);
                chk("beats", {aw_n[3:0], w_n[3:0], ar_n[3:0]}, t_write ? 12'h110 : 12'h001);
                last_lat = cyc - acc_cyc; last_resp = rsp_resp;
                last_rdata = rsp_rdata; last_write = rsp_write;
                active = 0; rsp_cnt++;
            end

            if (awvalid && awready) aw_n++;
            if (wvalid && wready) w_n++;
            if (active && t_write && aw_n > 0 && w_n > 0 && !b_issued) begin
                b_pend = 1; b_cnt = 0; b_issued = 1;
            end
            if (bvalid && bready) begin b_done = 1; b_pend = 0; end
            if (arvalid && arready) begin ar_n++; r_pend = 1; r_cnt = 0; end
            if (rvalid && rready) begin r_done = 1; r_pend = 0; end
            if (cmd_valid && cmd_ready) begin
                active = 1; t_write = cmd_write; t_addr = cmd_addr;
                t_data = cmd_wdata; t_strb = cmd_wstrb;
                aw_n = 0; w_n = 0; ar_n = 0; b_issued = 0; b_done = 0; r_done = 0;
                exp_rdata = cmd_write ? 32'h0 : cfg_rdata;
                exp_resp  = cmd_write ? cfg_bresp : (cfg_rlast ? cfg_rresp : 2'b10);
                acc_cyc = cyc; acc_cnt++;
            end
        end
    end

    task automatic drive_cmd(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    endtask

    task automatic wait_acc(input int unsigned start);
        for (int i = 0; i < 64 && acc_cnt == start; i++) begin @(posedge aclk); #2; end
        chk("cmd_accepted", acc_cnt - start, 1);
    endtask

    task automatic wait_rsp(input int unsigned start);
        for (int i = 0; i < 200 && rsp_cnt == start; i++) begin @(posedge aclk); #2; end
        chk("rsp_seen", rsp_cnt - start, 1);
    endtask

    task automatic issue(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned a0;
        a0 = acc_cnt;
        @(posedge aclk); #2;
        drive_cmd(w, a, d, s);
        wait_acc(a0);
        cmd_valid = 0; cmd_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic run_txn(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned r0;
        r0 = rsp_cnt;
        issue(w, a, d, s);
        wait_rsp(r0);
    endtask

    task automatic set_cfg(input int unsigned aw, input int unsigned wd, input int unsigned ar,
                           input int unsigned b, input int unsigned r);
        cfg_aw = aw; cfg_w = wd; cfg_ar = ar; cfg_b = b; cfg_r = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", nvec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r0, a0;
        aresetn = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        set_cfg(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0; cfg_rlast = 1;
        #22;
        chk("reset_payload", {awaddr, araddr, wdata, wstrb, rsp_resp}, '0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge aclk); #2; aresetn = 1;
        @(posedge aclk); #2;
        chk("ready_after_reset", cmd_ready, 1'b1);

        // basic write, all readies immediate
        run_txn(1, 3'd5, 32'hDEAD_BEEF, 4'hF);
        chk("wr_lat", last_lat, 3);
        chk("wr_resp", {last_write, last_resp, last_rdata}, {1'b1, 2'b00, 32'h0});

        // W accepted three cycles before AW
        set_cfg(3, 0, 0, 0, 0);
        run_txn(1, 3'd3, 32'hCAFE_F00D, 4'b0011);
        chk("wr_aw_late_lat", last_lat, 6);

        // slow W and slow B, slave error reported
        set_cfg(0, 2, 0, 2, 0); cfg_bresp = 2'b10;
        run_txn(1, 3'd7, 32'h0123_4567, 4'b0101);
        chk("wr_slow_lat", last_lat, 7);
        chk("wr_slverr", last_resp, 2'b10);
        cfg_bresp = 2'b00;

        // read with 4-cycle rvalid delay
        set_cfg(0, 0, 0, 0, 4); cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00; cfg_rlast = 1;
        run_txn(0, 3'd2, 32'h0, 4'h0);
        chk("rd_lat", last_lat, 7);
        chk("rd_data", {last_write, last_resp, last_rdata}, {1'b0, 2'b00, 32'h1234_5678});

        // missing rlast forces SLVERR
        set_cfg(0, 0, 1, 0, 0); cfg_rdata = 32'h0BAD_CAFE; cfg_rlast = 0;
        run_txn(0, 3'd1, 32'h0, 4'h0);
        chk("rd_no_rlast", last_resp, 2'b10);
        chk("rd_no_rlast_lat", last_lat, 4);
        cfg_rresp = 2'b01;
        run_txn(0, 3'd4, 32'h0, 4'h0);
        chk("rd_no_rlast_exok", last_resp, 2'b10);
        cfg_rlast = 1; cfg_rresp = 2'b11;
        run_txn(0, 3'd6, 32'h0, 4'h0);
        chk("rd_decerr", last_resp, 2'b11);
        cfg_rresp = 2'b00;

        // reset while AW is stalled
        set_cfg(20, 0, 0, 0, 0);
        r0 = rsp_cnt;
        issue(1, 3'd6, 32'h5555_AAAA, 4'hF);
        repeat (3) @(posedge aclk);
        #3;
        chk("pre_reset_awvalid", awvalid, 1'b1);
        aresetn = 0;
        #1;
        chk("abort_awvalid", awvalid, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        repeat (3) @(posedge aclk);
        #2; aresetn = 1;
        set_cfg(0, 0, 0, 0, 0);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        run_txn(1, 3'd1, 32'h7777_8888, 4'hC);
        chk("post_reset_lat", last_lat, 3);
        chk("post_reset_resp", last_resp, 2'b00);

        // cmd_valid held across two back-to-back commands
        set_cfg(1, 1, 0, 1, 0);
        r0 = rsp_cnt; a0 = acc_cnt;
        @(posedge aclk); #2;
        drive_cmd(1, 3'd2, 32'hAAAA_0001, 4'hF);
        wait_acc(a0);
        drive_cmd(0, 3'd3, 32'h0, 4'h0);
        cfg_rdata = 32'hFEED_0002;
        wait_acc(a0 + 1);
        chk("b2b_order", rsp_cnt - r0, 1);
        cmd_valid = 0;
        wait_rsp(r0 + 1);
        chk("b2b_second_rd", {last_write, last_rdata}, {1'b0, 32'hFEED_0002});

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
